// File: rtl/ipsxe_fft_rst_seq_ctrl_if.sv
// Status/handshake bundle between the FFT reset sequencer and the system side.
// The master drives the restart and ready inputs; the slave (sequencer) drives the stage resets and flags.
interface ipsxe_fft_rst_seq_ctrl_if #(
    parameter int unsigned N_STAGE = 3
);
    logic               i_soft_rst;
    logic               i_core_ready;
    logic [N_STAGE-1:0] o_stage_rstn;
    logic               o_busy;
    logic               o_init_done;
    logic               o_init_err;

    modport master (
        output i_soft_rst, i_core_ready,
        input  o_stage_rstn, o_busy, o_init_done, o_init_err
    );

    modport slave (
        input  i_soft_rst, i_core_ready,
        output o_stage_rstn, o_busy, o_init_done, o_init_err
    );
endinterface

// File: rtl/ipsxe_fft_rst_seq_ctrl.sv
// FFT reset sequencer: holds all stage resets, releases them in order with a fixed gap,
// then waits (with timeout) for the core to report ready and flags done or error.
module ipsxe_fft_rst_seq_ctrl #(
    parameter int unsigned N_STAGE  = 3,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned GAP_CYC  = 8,
    parameter int unsigned TO_CYC   = 1024,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    ipsxe_fft_rst_seq_ctrl_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(N_STAGE + 1);

    typedef enum logic [2:0] {
        S_ASSERT,
        S_RELEASE,
        S_WAIT_RDY,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_STAGE-1:0] stage_rstn_q, stage_rstn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_soft_rst) begin
            state_q      <= S_ASSERT;
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_rstn_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_rstn_q <= stage_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        stage_rstn_d = stage_rstn_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;

        // Releases are strictly in order, so setting bit idx is a shift-in of a one.
        unique case (state_q)
            S_ASSERT: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    stage_rstn_d = (stage_rstn_q << 1) | N_STAGE'(1);
                    cnt_d        = '0;
                    idx_d        = IDX_W'(1);
                    state_d      = (N_STAGE == 1) ? S_WAIT_RDY : S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    stage_rstn_d = (stage_rstn_q << 1) | N_STAGE'(1);
                    cnt_d        = '0;
                    idx_d        = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_STAGE - 1)) begin
                        state_d = S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                // Ready takes precedence over a coincident timeout.
                if (bus.i_core_ready) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
                    state_d = S_ERR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            S_ERR: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_ASSERT;
            end
        endcase
    end

    assign bus.o_stage_rstn = stage_rstn_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_init_done  = done_q;
    assign bus.o_init_err   = err_q;
endmodule

// File: tb/tb_ipsxe_fft_rst_seq_ctrl.sv
// Bench for the FFT reset sequencer: default configuration plus a minimal single-stage one,
// checked edge by edge against a timeline model derived from the release/timeout schedule.
module tb_ipsxe_fft_rst_seq_ctrl;
    localparam int A_N = 3, A_HOLD = 16, A_GAP = 8, A_TO = 1024;
    localparam int B_N = 1, B_HOLD = 1,  B_GAP = 1, B_TO = 1;
    localparam int NEVER = 1000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    ipsxe_fft_rst_seq_ctrl_if #(.N_STAGE(A_N)) ifa ();
    ipsxe_fft_rst_seq_ctrl_if #(.N_STAGE(B_N)) ifb ();

    ipsxe_fft_rst_seq_ctrl #(
        .N_STAGE(A_N), .HOLD_CYC(A_HOLD), .GAP_CYC(A_GAP), .TO_CYC(A_TO), .CNT_W(11)
    ) dut_a (
        .i_clk(clk), .i_rst(rst_a), .bus(ifa)
    );

    ipsxe_fft_rst_seq_ctrl #(
        .N_STAGE(B_N), .HOLD_CYC(B_HOLD), .GAP_CYC(B_GAP), .TO_CYC(B_TO), .CNT_W(2)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_b), .bus(ifb)
    );

    // Observed outputs packed as {rstn[2:0], busy, done, err}.
    function automatic logic [5:0] obs(input bit sel);
        if (!sel) return {ifa.o_stage_rstn, ifa.o_busy, ifa.o_init_done, ifa.o_init_err};
        else      return {2'b00, ifb.o_stage_rstn, ifb.o_busy, ifb.o_init_done, ifb.o_init_err};
    endfunction

    task automatic drive(input bit sel, input logic r, input logic s, input logic c);
        if (!sel) begin
            rst_a = r; ifa.i_soft_rst = s; ifa.i_core_ready = c;
        end else begin
            rst_b = r; ifb.i_soft_rst = s; ifb.i_core_ready = c;
        end
    endtask

    // Resets the chosen DUT, then runs n_edges edges. Ready is offered on sequence edges
    // ready_from..ready_until with probability ready_pct; soft reset is held on run edges
    // soft_from..soft_until, hard reset on run edges rst_at..rst_at+rst_len-1.
    task automatic run_seq(input string name, input bit sel, input int n_edges,
                           input int ready_from, input int ready_until, input int ready_pct,
                           input int soft_from, input int soft_until,
                           input int rst_at, input int rst_len);
        int hold, gap, ns, to, e, t, done_at;
        logic rdy, sf, rs, done, err;
        logic [5:0] expv, got;
        hold = sel ? B_HOLD : A_HOLD;
        gap  = sel ? B_GAP  : A_GAP;
        ns   = sel ? B_N    : A_N;
        to   = sel ? B_TO   : A_TO;
        e    = hold + (ns - 1) * gap;

        drive(sel, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        got = obs(sel);
        n_checks++;
        if (got !== 6'b000_100) begin
            n_fail++;
            $display("FAIL %s reset: got %b expected %b", name, got, 6'b000_100);
        end

        t = 0;
        done_at = -1;
        for (int n = 1; n <= n_edges; n++) begin
            rs  = (n >= rst_at) && (n < rst_at + rst_len);
            sf  = (n >= soft_from) && (n <= soft_until);
            rdy = (t + 1 >= ready_from) && (t + 1 <= ready_until) &&
                  (int'($urandom_range(99)) < ready_pct);
            drive(sel, rs, sf, rdy);
            @(posedge clk);
            #1;

            if (rs || sf) begin
                t = 0;
                done_at = -1;
            end else begin
                t++;
                if (done_at < 0 && rdy && t >= e + 1 && t <= e + to) done_at = t;
            end

            expv = '0;
            for (int k = 0; k < ns; k++) expv[3 + k] = (t >= hold + k * gap);
            done = (done_at >= 0);
            err  = (done_at < 0) && (t >= e + to);
            expv[2] = !done && !err;
            expv[1] = done;
            expv[0] = err;

            got = obs(sel);
            n_checks++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL %s edge %0d (seq %0d): got %b expected %b", name, n, t, got, expv);
            end
            n_checks++;
            if (got[1] && got[0]) begin
                n_fail++;
                $display("FAIL %s excl edge %0d: done=%b err=%b required not both", name, n, got[1], got[0]);
            end
        end
    endtask

    task automatic final_check(input string name, input bit sel, input logic [5:0] expv);
        logic [5:0] got;
        got = obs(sel);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s final: got %b expected %b", name, got, expv);
        end
    endtask

    task automatic test_reset();
        run_seq("soft_held", 0, 45, 0, NEVER, 100, 1, 10, 0, 0);
        final_check("soft_held", 0, 6'b111_010);
    endtask

    task automatic test_ready_high();
        run_seq("ready_high", 0, 50, 0, NEVER, 100, 0, -1, 0, 0);
        final_check("ready_high", 0, 6'b111_010);
    endtask

    task automatic test_timeout();
        run_seq("timeout", 0, 1160, NEVER, NEVER, 100, 0, -1, 0, 0);
        final_check("timeout", 0, 6'b111_001);
    endtask

    task automatic test_boundary();
        run_seq("ready_at_to", 0, 1070, 1056, NEVER, 100, 0, -1, 0, 0);
        final_check("ready_at_to", 0, 6'b111_010);
        run_seq("ready_at_entry", 0, 60, 32, 32, 100, 0, -1, 0, 0);
        final_check("ready_at_entry", 0, 6'b111_100);
        run_seq("ready_first", 0, 60, 33, 33, 100, 0, -1, 0, 0);
        final_check("ready_first", 0, 6'b111_010);
    endtask

    task automatic test_soft_release();
        run_seq("soft_release", 0, 70, 0, NEVER, 100, 20, 20, 0, 0);
        final_check("soft_release", 0, 6'b111_010);
    endtask

    task automatic test_soft_done_err();
        run_seq("soft_done", 0, 90, 0, NEVER, 100, 40, 40, 0, 0);
        final_check("soft_done", 0, 6'b111_010);
        run_seq("soft_err", 0, 2130, NEVER, NEVER, 100, 1060, 1060, 0, 0);
        final_check("soft_err", 0, 6'b111_001);
    endtask

    task automatic test_rst_mid_wait();
        run_seq("rst_mid_wait", 0, 80, 200, NEVER, 100, 0, -1, 40, 5);
        final_check("rst_mid_wait", 0, 6'b111_100);
    endtask

    task automatic test_small_cfg();
        run_seq("small_err", 1, 10, NEVER, NEVER, 100, 0, -1, 0, 0);
        final_check("small_err", 1, 6'b001_001);
        run_seq("small_done", 1, 10, 2, 2, 100, 0, -1, 0, 0);
        final_check("small_done", 1, 6'b001_010);
        run_seq("small_entry", 1, 10, 1, 1, 100, 0, -1, 0, 0);
        final_check("small_entry", 1, 6'b001_001);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            bit sel;
            int rf, pct, sa;
            sel = ($urandom_range(3) == 0);
            rf  = int'($urandom_range(80, 1));
            pct = int'($urandom_range(60, 1));
            sa  = ($urandom_range(1) == 0) ? -10 : int'($urandom_range(120, 1));
            run_seq("random", sel, 300, rf, NEVER, pct, sa, sa, 0, 0);
        end
    endtask

    initial begin
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        test_reset();
        test_ready_high();
        test_timeout();
        test_boundary();
        test_soft_release();
        test_soft_done_err();
        test_rst_mid_wait();
        test_small_cfg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
